dvfs_sequencer: RTL and testbench

- Sequences voltage/frequency operating-point changes requested by the DFS level selector (its 2-bit dfs_sel drives target_lvl).
- Enforces safe ordering:
  - Raising: voltage first, wait for settle, then clock.
  - Lowering: clock first, then voltage.
- Talks to the voltage regulator and clock mux over req/ack handshakes.
- Applies minimum dwell time and handshake timeout, and reports the committed operating level.

---
 rtl/dvfs_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_dvfs_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvfs_sequencer.sv
// dvfs_sequencer
// Orders voltage/frequency operating-point changes so the core never runs a
// clock faster than its supply allows. On a raise the regulator goes first,
// then a settle wait, then the clock mux. On a lower the clock mux goes first,
// then the regulator. Both sides use level-held req/ack handshakes guarded by
// a timeout. After every commit the new level is held for a minimum dwell time.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset (deassert synchronously upstream)
//   target_lvl      requested level: 00 LOW, 01 MED, 10 HIGH (11 behaves as 10)
//   vreg_req        voltage change request, held until vreg_ack
//   vreg_lvl        requested voltage level, stable while vreg_req=1
//   vreg_ack        regulator done, only looked at while vreg_req=1
//   clk_switch_req  clock switch request, held until clk_switch_done
//   clk_sel         requested clock level, stable while clk_switch_req=1
//   clk_switch_done mux done, only looked at while clk_switch_req=1
//   cur_lvl         committed operating level
//   busy            a transition is in progress
//   err             sticky handshake-timeout flag (cleared only by reset)
module dvfs_sequencer #(
   parameter int SETTLE_CYCLES = 16,
   parameter int MIN_DWELL     = 64,
   parameter int TIMEOUT       = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] target_lvl,
   output logic       vreg_req,
   output logic [1:0] vreg_lvl,
   input  logic       vreg_ack,
   output logic       clk_switch_req,
   output logic [1:0] clk_sel,
   input  logic       clk_switch_done,
   output logic [1:0] cur_lvl,
   output logic       busy,
   output logic       err
);

   localparam int DW_W = $clog2(MIN_DWELL + 1);
   localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
   localparam int TO_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_V_UP     = 3'd1;
   localparam logic [2:0] ST_V_SETTLE = 3'd2;
   localparam logic [2:0] ST_F_SW     = 3'd3;
   localparam logic [2:0] ST_V_DOWN   = 3'd4;
   localparam logic [2:0] ST_ERR      = 3'd5;

   logic [2:0]      state_q,    state_d;
   logic [1:0]      tgt_q,      tgt_d;
   logic [1:0]      cur_lvl_q,  cur_lvl_d;
   logic            vreg_req_q, vreg_req_d;
   logic [1:0]      vreg_lvl_q, vreg_lvl_d;
   logic            clk_req_q,  clk_req_d;
   logic [1:0]      clk_sel_q,  clk_sel_d;
   logic            busy_q,     busy_d;
   logic            err_q,      err_d;
   logic [DW_W-1:0] dwell_q,    dwell_d;
   logic [ST_W-1:0] settle_q,   settle_d;
   logic [TO_W-1:0] to_q,       to_d;

   logic [1:0] tgt_norm;
   logic       to_expired;
   logic       commit;
   logic       hs_fail;

   // 11 has no operating point of its own; it aliases HIGH.
   assign tgt_norm   = (target_lvl == 2'b11) ? 2'b10 : target_lvl;

   // The handshake counter holds the number of cycles the current req has
   // already been high without an ack. An ack seen in the cycle the count
   // equals TIMEOUT still wins; only a missing ack there is a failure.
   assign to_expired = (to_q == TO_W'(TIMEOUT));

   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      cur_lvl_d  = cur_lvl_q;
      vreg_req_d = vreg_req_q;
      vreg_lvl_d = vreg_lvl_q;
      clk_req_d  = clk_req_q;
      clk_sel_d  = clk_sel_q;
      busy_d     = busy_q;
      err_d      = err_q;
      dwell_d    = dwell_q;
      settle_d   = settle_q;
      to_d       = to_q;
      commit     = 1'b0;
      hs_fail    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (dwell_q != '0) begin
               dwell_d = dwell_q - 1'b1;
            end else if (tgt_norm != cur_lvl_q) begin
               tgt_d  = tgt_norm;
               busy_d = 1'b1;
               to_d   = '0;
               if (tgt_norm > cur_lvl_q) begin
                  state_d    = ST_V_UP;
                  vreg_req_d = 1'b1;
                  vreg_lvl_d = tgt_norm;
               end else begin
                  state_d   = ST_F_SW;
                  clk_req_d = 1'b1;
                  clk_sel_d = tgt_norm;
               end
            end
         end

         ST_V_UP: begin
            if (vreg_ack) begin
               vreg_req_d = 1'b0;
               settle_d   = ST_W'(SETTLE_CYCLES);
               state_d    = ST_V_SETTLE;
            end else if (to_expired) begin
               hs_fail = 1'b1;
            end else begin
               to_d = to_q + 1'b1;
            end
         end

         ST_V_SETTLE: begin
            // Leave on the cycle the count would reach zero so the clock
            // request appears exactly SETTLE_CYCLES cycles after vreg_req drops.
            if (settle_q <= ST_W'(1)) begin
               state_d   = ST_F_SW;
               clk_req_d = 1'b1;
               clk_sel_d = tgt_q;
               to_d      = '0;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end

         ST_F_SW: begin
            if (clk_switch_done) begin
               clk_req_d = 1'b0;
               if (tgt_q > cur_lvl_q) begin
                  commit = 1'b1;
               end else begin
                  state_d    = ST_V_DOWN;
                  vreg_req_d = 1'b1;
                  vreg_lvl_d = tgt_q;
                  to_d       = '0;
               end
            end else if (to_expired) begin
               hs_fail = 1'b1;
            end else begin
               to_d = to_q + 1'b1;
            end
         end

         ST_V_DOWN: begin
            if (vreg_ack) begin
               vreg_req_d = 1'b0;
               commit     = 1'b1;
            end else if (to_expired) begin
               hs_fail = 1'b1;
            end else begin
               to_d = to_q + 1'b1;
            end
         end

         ST_ERR: begin
            // Terminal: nothing moves until reset.
         end

         default: begin
            vreg_req_d = 1'b0;
            clk_req_d  = 1'b0;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase

      if (commit) begin
         cur_lvl_d = tgt_q;
         dwell_d   = DW_W'(MIN_DWELL);
         busy_d    = 1'b0;
         state_d   = ST_IDLE;
      end

      // A stuck handshake leaves whatever was already applied in place;
      // a voltage raised ahead of a failed clock switch is the safe side.
      if (hs_fail) begin
         vreg_req_d = 1'b0;
         clk_req_d  = 1'b0;
         busy_d     = 1'b0;
         err_d      = 1'b1;
         state_d    = ST_ERR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         tgt_q      <= 2'b00;
         cur_lvl_q  <= 2'b00;
         vreg_req_q <= 1'b0;
         vreg_lvl_q <= 2'b00;
         clk_req_q  <= 1'b0;
         clk_sel_q  <= 2'b00;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         dwell_q    <= '0;    // expired: first differing target is taken at once
         settle_q   <= '0;
         to_q       <= '0;
      end else begin
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         cur_lvl_q  <= cur_lvl_d;
         vreg_req_q <= vreg_req_d;
         vreg_lvl_q <= vreg_lvl_d;
         clk_req_q  <= clk_req_d;
         clk_sel_q  <= clk_sel_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         dwell_q    <= dwell_d;
         settle_q   <= settle_d;
         to_q       <= to_d;
      end
   end

   assign vreg_req       = vreg_req_q;
   assign vreg_lvl       = vreg_lvl_q;
   assign clk_switch_req = clk_req_q;
   assign clk_sel        = clk_sel_q;
   assign cur_lvl        = cur_lvl_q;
   assign busy           = busy_q;
   assign err            = err_q;

endmodule

// File: tb/tb_dvfs_sequencer.sv
// tb_dvfs_sequencer
// Self-checking bench for dvfs_sequencer. A reference model describes each
// transition as a plan of steps (voltage handshake, settle wait, clock
// handshake) with deadlines kept as absolute cycle numbers; a compare process
// checks every DUT output against it each cycle. Directed scenarios add
// literal expectations for latencies and boundaries; a random phase drives
// random targets, ack delays and spurious acks.
`timescale 1ns/1ps
module tb_dvfs_sequencer;

   localparam int SETTLE = 16;
   localparam int DWELL  = 64;
   localparam int TMO    = 255;

   logic       clk             = 1'b0;
   logic       rst_n           = 1'b0;
   logic [1:0] target_lvl      = 2'b00;
   logic       vreg_ack        = 1'b0;
   logic       clk_switch_done = 1'b0;
   logic       vreg_req, clk_switch_req, busy, err;
   logic [1:0] vreg_lvl, clk_sel, cur_lvl;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // responder configuration: ack N cycles into the req (-1 = never)
   int v_delay = 0;
   int c_delay = 0;
   bit spur    = 1'b0;
   int v_age   = 0;
   int c_age   = 0;

   dvfs_sequencer #(
      .SETTLE_CYCLES (SETTLE),
      .MIN_DWELL     (DWELL),
      .TIMEOUT       (TMO)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .target_lvl      (target_lvl),
      .vreg_req        (vreg_req),
      .vreg_lvl        (vreg_lvl),
      .vreg_ack        (vreg_ack),
      .clk_switch_req  (clk_switch_req),
      .clk_sel         (clk_sel),
      .clk_switch_done (clk_switch_done),
      .cur_lvl         (cur_lvl),
      .busy            (busy),
      .err             (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {S_V, S_W, S_C} step_t;
   step_t      plan[$];
   logic [1:0] m_cur, m_vlvl, m_csel, m_tgt;
   bit         m_vreq, m_creq, m_busy, m_err;
   int         dwell_until, step_start;

   function automatic logic [1:0] norm(input logic [1:0] l);
      return (l == 2'b11) ? 2'b10 : l;
   endfunction

   task automatic m_reset();
      plan.delete();
      m_cur = 2'b00; m_vlvl = 2'b00; m_csel = 2'b00; m_tgt = 2'b00;
      m_vreq = 1'b0; m_creq = 1'b0; m_busy = 1'b0; m_err = 1'b0;
      dwell_until = 0; step_start = 0;
   endtask

   // Begin the next planned step in cycle t, or commit if the plan is done.
   task automatic m_next(input int t);
      if (plan.size() == 0) begin
         m_cur       = m_tgt;
         m_busy      = 1'b0;
         dwell_until = t + DWELL;
      end else begin
         step_start = t;
         if (plan[0] == S_V) begin
            m_vreq = 1'b1; m_vlvl = m_tgt;
         end else if (plan[0] == S_C) begin
            m_creq = 1'b1; m_csel = m_tgt;
         end
      end
   endtask

   task automatic m_fail();
      plan.delete();
      m_vreq = 1'b0; m_creq = 1'b0; m_busy = 1'b0; m_err = 1'b1;
   endtask

   // Evaluate the edge that ends cycle k, given that cycle's inputs.
   task automatic m_step(input int k, input logic [1:0] tl, input bit va, input bit cd);
      if (m_err) return;
      if (plan.size() == 0) begin
         if (k >= dwell_until && norm(tl) != m_cur) begin
            m_tgt  = norm(tl);
            m_busy = 1'b1;
            if (m_tgt > m_cur) begin
               plan.push_back(S_V); plan.push_back(S_W); plan.push_back(S_C);
            end else begin
               plan.push_back(S_C); plan.push_back(S_V);
            end
            m_next(k + 1);
         end
      end else begin
         case (plan[0])
            S_V: begin
               if (va) begin
                  m_vreq = 1'b0; void'(plan.pop_front()); m_next(k + 1);
               end else if (k - step_start == TMO) m_fail();
            end
            S_C: begin
               if (cd) begin
                  m_creq = 1'b0; void'(plan.pop_front()); m_next(k + 1);
               end else if (k - step_start == TMO) m_fail();
            end
            default: begin
               if (k + 1 == step_start + SETTLE) begin
                  void'(plan.pop_front()); m_next(k + 1);
               end
            end
         endcase
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else m_step(cyc, target_lvl, vreg_ack, clk_switch_done);
      end
   end

   // ---------------- responder ----------------
   initial forever begin
      @(negedge clk);
      v_age = vreg_req ? v_age + 1 : 0;
      c_age = clk_switch_req ? c_age + 1 : 0;
      vreg_ack        = vreg_req ? (v_delay >= 0 && v_age > v_delay) : spur;
      clk_switch_done = clk_switch_req ? (c_delay >= 0 && c_age > c_delay) : spur;
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      chk("cmp_vreg_req", int'(vreg_req),       int'(m_vreq));
      chk("cmp_vreg_lvl", int'(vreg_lvl),       int'(m_vlvl));
      chk("cmp_clk_req",  int'(clk_switch_req), int'(m_creq));
      chk("cmp_clk_sel",  int'(clk_sel),        int'(m_csel));
      chk("cmp_cur_lvl",  int'(cur_lvl),        int'(m_cur));
      chk("cmp_busy",     int'(busy),           int'(m_busy));
      chk("cmp_err",      int'(err),            int'(m_err));
   end

   // ---------------- transaction observer ----------------
   int t_vrise, t_vfall, t_crise, t_cfall, t_commit, lvl_v, lvl_c;

   task automatic run_txn(input int max_cyc);
      bit pv, pc, seen_busy, done;
      pv = vreg_req; pc = clk_switch_req; seen_busy = busy; done = 1'b0;
      t_vrise = -1; t_vfall = -1; t_crise = -1; t_cfall = -1; t_commit = -1;
      lvl_v = -1; lvl_c = -1;
      for (int i = 0; i < max_cyc && !done; i++) begin
         @(negedge clk);
         if (vreg_req && !pv) begin t_vrise = cyc; lvl_v = int'(vreg_lvl); end
         if (!vreg_req && pv) t_vfall = cyc;
         if (clk_switch_req && !pc) begin t_crise = cyc; lvl_c = int'(clk_sel); end
         if (!clk_switch_req && pc) t_cfall = cyc;
         pv = vreg_req; pc = clk_switch_req;
         if (busy) seen_busy = 1'b1;
         if (err) done = 1'b1;
         else if (seen_busy && !busy) begin done = 1'b1; t_commit = cyc; end
      end
      chk("txn_within_bound", int'(done), 1);
   endtask

   task automatic rst_now_checked(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_vreg_req"}, int'(vreg_req),       0);
      chk({tag, "_vreg_lvl"}, int'(vreg_lvl),       0);
      chk({tag, "_clk_req"},  int'(clk_switch_req), 0);
      chk({tag, "_clk_sel"},  int'(clk_sel),        0);
      chk({tag, "_cur_lvl"},  int'(cur_lvl),        0);
      chk({tag, "_busy"},     int'(busy),           0);
      chk({tag, "_err"},      int'(err),            0);
   endtask

   // ---------------- stimulus ----------------
   int t_set, cnt;
   bit ok, seen;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_vreg_req", int'(vreg_req), 0);
      chk("reset_clk_req",  int'(clk_switch_req), 0);
      chk("reset_cur_lvl",  int'(cur_lvl), 0);
      chk("reset_busy",     int'(busy), 0);
      chk("reset_err",      int'(err), 0);
      rst_n = 1'b1;

      // raise LOW->HIGH, ack 3 cycles in, done 2 cycles in
      @(negedge clk);
      v_delay = 3; c_delay = 2; target_lvl = 2'b10; t_set = cyc;
      run_txn(400);
      $display("txn raise 0->2: vrise=%0d vfall=%0d crise=%0d commit=%0d", t_vrise, t_vfall, t_crise, t_commit);
      chk("t1_req_latency", t_vrise - t_set, 1);
      chk("t1_vreg_lvl",    lvl_v, 2);
      chk("t1_settle_gap",  t_crise - t_vfall, SETTLE);
      chk("t1_clk_sel",     lvl_c, 2);
      chk("t1_commit_lat",  t_commit - t_set, 24);
      chk("t1_cur_lvl",     int'(cur_lvl), 2);

      // lower HIGH->MED, requested right at commit; gated by dwell
      v_delay = 0; c_delay = 0; target_lvl = 2'b01; t_set = cyc;
      run_txn(400);
      $display("txn lower 2->1: crise=%0d vrise=%0d commit=%0d", t_crise, t_vrise, t_commit);
      chk("t2_clk_first",   int'(t_crise < t_vrise), 1);
      chk("t2_clk_sel",     lvl_c, 1);
      chk("t2_vreg_lvl",    lvl_v, 1);
      chk("t2_dwell_start", t_crise - t_set, DWELL + 1);
      chk("t2_commit_lat",  t_commit - t_set, DWELL + 3);
      chk("t2_cur_lvl",     int'(cur_lvl), 1);

      // dwell gating: change target 10 cycles after commit
      t_set = cyc;
      repeat (10) @(negedge clk);
      target_lvl = 2'b00;
      run_txn(400);
      $display("txn lower 1->0 dwell: crise=%0d commit=%0d", t_crise, t_commit);
      chk("t3_dwell_gate", t_crise - t_set, DWELL + 1);
      chk("t3_cur_lvl",    int'(cur_lvl), 0);

      // target 11 aliases HIGH
      v_delay = 1; c_delay = 4; target_lvl = 2'b11;
      run_txn(400);
      $display("txn raise 0->3: vlvl=%0d csel=%0d cur=%0d", lvl_v, lvl_c, cur_lvl);
      chk("t6a_vreg_lvl", lvl_v, 2);
      chk("t6a_clk_sel",  lvl_c, 2);
      chk("t6a_cur_lvl",  int'(cur_lvl), 2);

      // spurious acks while idle
      spur = 1'b1; cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (vreg_req || clk_switch_req || busy) cnt++;
      end
      spur = 1'b0;
      $display("txn spurious acks idle: activity=%0d", cnt);
      chk("t5b_quiet",   cnt, 0);
      chk("t5b_cur_lvl", int'(cur_lvl), 2);

      // done arrives in the very cycle the timeout count is reached
      v_delay = 0; c_delay = TMO; target_lvl = 2'b00;
      run_txn(800);
      $display("txn lower 2->0 boundary: crise=%0d cfall=%0d err=%0d", t_crise, t_cfall, err);
      chk("t5a_req_cycles", t_cfall - t_crise, TMO + 1);
      chk("t5a_err",        int'(err), 0);
      chk("t5a_cur_lvl",    int'(cur_lvl), 0);

      // random traffic
      for (int it = 0; it < 40; it++) begin
         target_lvl = 2'($urandom_range(0, 3));
         v_delay    = int'($urandom_range(0, 8));
         c_delay    = int'($urandom_range(0, 8));
         spur       = ($urandom_range(0, 3) == 0);
         repeat ($urandom_range(5, 120)) @(negedge clk);
         $display("txn random %0d: target=%0d cur=%0d busy=%0d", it, target_lvl, cur_lvl, busy);
      end
      spur = 1'b0; v_delay = 0; c_delay = 0;

      // reset during the settle wait
      @(negedge clk);
      #2 rst_n = 1'b0; target_lvl = 2'b10;
      @(negedge clk); rst_n = 1'b1;
      ok = 1'b0; seen = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (vreg_req) seen = 1'b1;
         else if (seen) ok = 1'b1;
      end
      chk("t6b_in_settle", int'(ok), 1);
      repeat (3) @(negedge clk);
      rst_now_checked("t6b_rst");
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      $display("txn reset mid-settle: vreg_req after release=%0d", vreg_req);
      chk("t6b_no_dwell_req", int'(vreg_req), 1);
      chk("t6b_vreg_lvl",     int'(vreg_lvl), 2);
      run_txn(200);
      chk("t6b_cur_lvl", int'(cur_lvl), 2);

      // voltage handshake timeout
      @(negedge clk);
      #2 rst_n = 1'b0; target_lvl = 2'b01; v_delay = -1;
      @(negedge clk); rst_n = 1'b1;
      run_txn(600);
      $display("txn timeout: vrise=%0d vfall=%0d err=%0d", t_vrise, t_vfall, err);
      chk("t4_req_cycles", t_vfall - t_vrise, TMO + 1);
      chk("t4_err",        int'(err), 1);
      chk("t4_busy",       int'(busy), 0);
      chk("t4_vreg_req",   int'(vreg_req), 0);
      chk("t4_cur_lvl",    int'(cur_lvl), 0);
      target_lvl = 2'b10; cnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (vreg_req || clk_switch_req || busy) cnt++;
      end
      chk("t4_err_quiet", cnt, 0);
      chk("t4_err_held",  int'(err), 1);
      #2 rst_n = 1'b0;
      #1 chk("t4_rst_clears_err", int'(err), 0);
      @(negedge clk); rst_n = 1'b1; v_delay = 0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
